alu_decode_stage: RTL and testbench

Registered decode stage that turns a 32-bit MIPS instruction word into the control bundle consumed by the ALU: 4-bit ALU pattern, operand-source selects, register indices and write-back control. Sits between instruction fetch and the register-read/ALU stage. It is the producer side of the ALU pattern interface. It uses a valid/ready handshake on both sides with a single pipeline register, a synchronous flush, and an illegal-instruction flag.

---
 rtl/alu_decode_stage.sv | 167 ++++++++++++++++
 tb/tb_alu_decode_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Registered decode stage between instruction fetch and register-read/ALU.
// Turns a 32-bit MIPS instruction word into the ALU control bundle and holds
// it in a single pipeline register behind a valid/ready handshake.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready = !out_valid || out_ready)
//   in_instr[31:0]     instruction word
//   flush              synchronous discard of held entry and current input
//   out_valid/out_ready downstream handshake
//   alu_pattern[3:0]   0 pass-A,1 add,2 and,3 or,4 sll,5 srl,6 sub,7 sra,8 slt,9 nor
//   sel_a[1:0]         0 reg[rs], 1 zext shamt, 2 imm16<<16
//   sel_b[1:0]         0 reg[rt], 1 sext imm16, 2 zext imm16
//   rs, rt, rd[4:0]    register indices; rd is the resolved destination
//   imm[15:0], shamt[4:0] raw instruction fields
//   wb_en              write-back enable (legal and rd != 0)
//   illegal            unsupported opcode/funct; bundle still issues
module alu_decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_pattern,
  output logic [1:0]  sel_a,
  output logic [1:0]  sel_b,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [4:0]  shamt,
  output logic        wb_en,
  output logic        illegal
);

  typedef struct packed {
    logic        illegal;
    logic        wb_en;
    logic [3:0]  pattern;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [4:0]  shamt;
  } bundle_t;

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic       legal_s;
  logic       dest_rt_s;
  logic [4:0] dest_s;
  bundle_t    dec_s;
  logic       accept_s;

  bundle_t    bundle_d, bundle_q;
  logic       valid_d, valid_q;

  assign op_s    = in_instr[31:26];
  assign funct_s = in_instr[5:0];

  // Combinational decode of the offered instruction into a control bundle.
  always_comb begin
    dec_s         = '0;
    legal_s       = 1'b1;
    dest_rt_s     = 1'b0;
    dec_s.rs      = in_instr[25:21];
    dec_s.rt      = in_instr[20:16];
    dec_s.imm     = in_instr[15:0];
    dec_s.shamt   = in_instr[10:6];
    if (op_s == 6'h00) begin
      // R-type: operand B is always reg[rt]; fixed-amount shifts take A from shamt.
      case (funct_s)
        6'h20, 6'h21: dec_s.pattern = 4'd1;
        6'h22, 6'h23: dec_s.pattern = 4'd6;
        6'h24:        dec_s.pattern = 4'd2;
        6'h25:        dec_s.pattern = 4'd3;
        6'h27:        dec_s.pattern = 4'd9;
        6'h2A:        dec_s.pattern = 4'd8;
        6'h00: begin dec_s.pattern = 4'd4; dec_s.sel_a = 2'd1; end
        6'h02: begin dec_s.pattern = 4'd5; dec_s.sel_a = 2'd1; end
        6'h03: begin dec_s.pattern = 4'd7; dec_s.sel_a = 2'd1; end
        6'h04:        dec_s.pattern = 4'd4;
        6'h06:        dec_s.pattern = 4'd5;
        6'h07:        dec_s.pattern = 4'd7;
        default:      legal_s = 1'b0;
      endcase
    end else begin
      dest_rt_s = 1'b1;
      case (op_s)
        6'h08, 6'h09: begin dec_s.pattern = 4'd1; dec_s.sel_b = 2'd1; end
        6'h0A:        begin dec_s.pattern = 4'd8; dec_s.sel_b = 2'd1; end
        6'h0C:        begin dec_s.pattern = 4'd2; dec_s.sel_b = 2'd2; end
        6'h0D:        begin dec_s.pattern = 4'd3; dec_s.sel_b = 2'd2; end
        6'h0F:        begin dec_s.pattern = 4'd0; dec_s.sel_a = 2'd2; end
        default:      legal_s = 1'b0;
      endcase
    end

    if (dest_rt_s) begin
      dest_s = in_instr[20:16];
    end else begin
      dest_s = in_instr[15:11];
    end

    if (legal_s) begin
      dec_s.rd    = dest_s;
      dec_s.wb_en = (dest_s != 5'd0);
    end else begin
      // Unsupported encodings issue as a harmless pass-A with no write-back.
      dec_s.illegal = 1'b1;
      dec_s.pattern = 4'd0;
      dec_s.sel_a   = 2'd0;
      dec_s.sel_b   = 2'd0;
      dec_s.rd      = 5'd0;
      dec_s.wb_en   = 1'b0;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Next-state for the pipeline register: flush beats accept beats pop/hold.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d  = 1'b1;
      bundle_d = dec_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid   = valid_q;
  assign alu_pattern = bundle_q.pattern;
  assign sel_a       = bundle_q.sel_a;
  assign sel_b       = bundle_q.sel_b;
  assign rs          = bundle_q.rs;
  assign rt          = bundle_q.rt;
  assign rd          = bundle_q.rd;
  assign imm         = bundle_q.imm;
  assign shamt       = bundle_q.shamt;
  assign wb_en       = bundle_q.wb_en;
  assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: the driver pushes hand-computed
// bundles when an instruction is accepted; the monitor pops and compares
// whenever the DUT completes an output handshake.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_pattern;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        wb_en;
  logic        illegal;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [45:0] exp_q[$];
  int pop_cyc[$];

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_pattern(alu_pattern), .sel_a(sel_a),
    .sel_b(sel_b), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .shamt(shamt),
    .wb_en(wb_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [45:0] cur();
    return {illegal, wb_en, alu_pattern, sel_a, sel_b, rs, rt, rd, imm, shamt};
  endfunction

  // Expected bundle: decode results are hand-computed; raw fields come from the word.
  function automatic logic [45:0] mk(input logic [31:0] ins, input logic ill,
                                     input logic wb, input logic [3:0] pat,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [4:0] d);
    return {ill, wb, pat, sa, sb, ins[25:21], ins[20:16], d, ins[15:0], ins[10:6]};
  endfunction

  task automatic chk(input string name, input logic [45:0] got, input logic [45:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Offer one instruction; push its expected bundle once it is seen accepted.
  task automatic send(input logic [31:0] ins, input logic [45:0] e);
    int n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every completed output handshake against the scoreboard.
  initial begin
    logic [45:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bundle: got %h expected none", cur());
        end else begin
          e = exp_q.pop_front();
          chk("bundle", cur(), e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [45:0] ea;
    int p0;
    rst = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h02328020;
    flush = 1'b0;
    out_ready = 1'b1;

    // Reset with input offered: nothing issues, fields clear, in_ready high.
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {45'd0, out_valid}, 46'd0);
    chk("rst_bundle", cur(), 46'd0);
    chk("rst_ready", {45'd0, in_ready}, 46'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);

    // Single decodes.
    send(32'h02328020, mk(32'h02328020, 1'b0, 1'b1, 4'd1, 2'd0, 2'd0, 5'd16));
    send(32'h2008FFFF, mk(32'h2008FFFF, 1'b0, 1'b1, 4'd1, 2'd0, 2'd1, 5'd8));
    send(32'h3C091234, mk(32'h3C091234, 1'b0, 1'b1, 4'd0, 2'd2, 2'd0, 5'd9));
    send(32'h00084080, mk(32'h00084080, 1'b0, 1'b1, 4'd4, 2'd1, 2'd0, 5'd8));
    send(32'h00084082, mk(32'h00084082, 1'b0, 1'b1, 4'd5, 2'd1, 2'd0, 5'd8));
    send(32'h00000000, mk(32'h00000000, 1'b0, 1'b0, 4'd4, 2'd1, 2'd0, 5'd0));
    send(32'h8C080000, mk(32'h8C080000, 1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 5'd0));
    send(32'h02328001, mk(32'h02328001, 1'b1, 1'b0, 4'd0, 2'd0, 2'd0, 5'd0));
    send(32'h310800FF, mk(32'h310800FF, 1'b0, 1'b1, 4'd2, 2'd0, 2'd2, 5'd8));
    send(32'h3508FFFF, mk(32'h3508FFFF, 1'b0, 1'b1, 4'd3, 2'd0, 2'd2, 5'd8));
    send(32'h2809FFFF, mk(32'h2809FFFF, 1'b0, 1'b1, 4'd8, 2'd0, 2'd1, 5'd9));
    send(32'h20000005, mk(32'h20000005, 1'b0, 1'b0, 4'd1, 2'd0, 2'd1, 5'd0));
    idle(3);

    // Back-to-back stream of 8 with out_ready high: expect 8 pops on 8 consecutive cycles.
    p0 = pop_cyc.size();
    send(32'h02328022, mk(32'h02328022, 1'b0, 1'b1, 4'd6, 2'd0, 2'd0, 5'd16));
    send(32'h02328024, mk(32'h02328024, 1'b0, 1'b1, 4'd2, 2'd0, 2'd0, 5'd16));
    send(32'h02328025, mk(32'h02328025, 1'b0, 1'b1, 4'd3, 2'd0, 2'd0, 5'd16));
    send(32'h02328027, mk(32'h02328027, 1'b0, 1'b1, 4'd9, 2'd0, 2'd0, 5'd16));
    send(32'h0232802A, mk(32'h0232802A, 1'b0, 1'b1, 4'd8, 2'd0, 2'd0, 5'd16));
    send(32'h02328004, mk(32'h02328004, 1'b0, 1'b1, 4'd4, 2'd0, 2'd0, 5'd16));
    send(32'h02328007, mk(32'h02328007, 1'b0, 1'b1, 4'd7, 2'd0, 2'd0, 5'd16));
    send(32'h00084083, mk(32'h00084083, 1'b0, 1'b1, 4'd7, 2'd1, 2'd0, 5'd8));
    idle(3);
    chk("stream_count", 46'(pop_cyc.size() - p0), 46'd8);
    if (pop_cyc.size() - p0 == 8) begin
      chk("stream_span", 46'(pop_cyc[p0 + 7] - pop_cyc[p0]), 46'd7);
    end else begin
      chk("stream_span", 46'd0, 46'd7);
    end

    // Stall for 3 cycles with a new word offered, then release and replace same cycle.
    out_ready = 1'b0;
    ea = mk(32'h02328020, 1'b0, 1'b1, 4'd1, 2'd0, 2'd0, 5'd16);
    send(32'h02328020, ea);
    in_valid = 1'b1;
    in_instr = 32'h3C091234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_bundle", cur(), ea);
      chk("stall_valid", {45'd0, out_valid}, 46'd1);
      chk("stall_ready", {45'd0, in_ready}, 46'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h3C091234, mk(32'h3C091234, 1'b0, 1'b1, 4'd0, 2'd2, 2'd0, 5'd9));
    @(negedge clk);
    chk("replace_valid", {45'd0, out_valid}, 46'd1);
    @(posedge clk);
    #1;
    idle(2);

    // Flush while stalled: held entry dropped, flush-cycle input never emitted.
    out_ready = 1'b0;
    send(32'h2008FFFF, mk(32'h2008FFFF, 1'b0, 1'b1, 4'd1, 2'd0, 2'd1, 5'd8));
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00084080;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_stall_valid", {45'd0, out_valid}, 46'd0);

    // Flush while empty: in_ready stays high but the offered word is dropped.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h02328025;
    @(negedge clk);
    chk("flush_ready", {45'd0, in_ready}, 46'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_empty_valid", {45'd0, out_valid}, 46'd0);
    idle(2);

    // Reset mid-stall: out_valid clears asynchronously.
    out_ready = 1'b0;
    send(32'h02328024, mk(32'h02328024, 1'b0, 1'b1, 4'd2, 2'd0, 2'd0, 5'd16));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {45'd0, out_valid}, 46'd0);
    exp_q.delete();
    @(negedge clk);
    chk("async_rst_bundle", cur(), 46'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(3);

    chk("scoreboard_empty", 46'(exp_q.size()), 46'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
